// File: rtl/ibniz_pkg.sv
// Shared types and widths for the Ibniz scene sequencer.
// Scene numbering matches the generator mux inputs.
package ibniz_pkg;

    localparam int SCENE_W = 3;
    localparam int T_W     = 16;
    localparam int FADE_W  = 8;

    typedef enum logic [1:0] {
        HOLD,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } seq_state_e;

    localparam logic [SCENE_W-1:0] SC_MUNCHING = 3'd0;
    localparam logic [SCENE_W-1:0] SC_XOR      = 3'd1;
    localparam logic [SCENE_W-1:0] SC_PLASMA   = 3'd2;
    localparam logic [SCENE_W-1:0] SC_RINGS    = 3'd3;
    localparam logic [SCENE_W-1:0] SC_TUNNEL   = 3'd4;
    localparam logic [SCENE_W-1:0] SC_STARS    = 3'd5;
    localparam logic [SCENE_W-1:0] SC_WAVES    = 3'd6;
    localparam logic [SCENE_W-1:0] SC_TEST     = 3'd7;

endpackage

// File: rtl/ibniz_scene_sequencer_if.sv
// Control/status bundle between frame timing and the scene sequencer.
// IBNIZ_SEQ_PAUSE_EN adds the pause request line.
interface ibniz_scene_sequencer_if;
    import ibniz_pkg::*;

    logic               end_frame;
    logic [SCENE_W-1:0] tumblers;
    logic               auto_en;
    logic               next_req;
`ifdef IBNIZ_SEQ_PAUSE_EN
    logic               pause;
`endif
    logic [SCENE_W-1:0] scene_sel;
    logic [T_W-1:0]     t_frame;
    logic [FADE_W-1:0]  fade;
    logic               scene_switch;

    modport master (
        output end_frame, tumblers, auto_en, next_req,
`ifdef IBNIZ_SEQ_PAUSE_EN
        output pause,
`endif
        input  scene_sel, t_frame, fade, scene_switch
    );

    modport slave (
        input  end_frame, tumblers, auto_en, next_req,
`ifdef IBNIZ_SEQ_PAUSE_EN
        input  pause,
`endif
        output scene_sel, t_frame, fade, scene_switch
    );

endinterface

// File: rtl/ibniz_next_scene.sv
// Finds the first enabled scene after cur_i, wrapping 7->0.
// Returns cur_i itself when no other scene is enabled.
module ibniz_next_scene
    import ibniz_pkg::*;
(
    input  logic [SCENE_W-1:0]      cur_i,
    input  logic [(1<<SCENE_W)-1:0] mask_i,
    output logic [SCENE_W-1:0]      nxt_o
);

    // Walk offsets downward so the nearest enabled scene wins.
    always_comb begin
        nxt_o = cur_i;
        for (int k = (1 << SCENE_W) - 1; k >= 1; k--) begin
            if (mask_i[cur_i + SCENE_W'(k)]) begin
                nxt_o = cur_i + SCENE_W'(k);
            end
        end
    end

endmodule

// File: rtl/ibniz_scene_sequencer.sv
// Frame-synchronous scene selector with fade-out/switch/fade-in sequencing.
// Optional IBNIZ_SEQ_PAUSE_EN freezes all frame-driven progress while pause=1.
module ibniz_scene_sequencer
    import ibniz_pkg::*;
#(
    parameter int unsigned      HOLD_FRAMES = 600,
    parameter int unsigned      FADE_STEP   = 8,
    parameter logic [7:0]       SCENE_MASK  = 8'hFF,
    parameter logic [SCENE_W-1:0] INIT_SCENE = 3'd7
) (
    input logic clk,
    input logic rst,
    ibniz_scene_sequencer_if.slave bus
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [FADE_W:0]   STEP9     = {1'b0, FADE_W'(FADE_STEP)};

    seq_state_e         state_q;
    logic [HW-1:0]      hold_q;
    logic [SCENE_W-1:0] scene_q;
    logic [SCENE_W-1:0] target_q;
    logic [T_W-1:0]     t_q;
    logic [FADE_W-1:0]  fade_q;
    logic               sw_q;

    logic               ef;
    logic [SCENE_W-1:0] auto_nxt;
    logic [SCENE_W-1:0] tum_nxt;
    logic               tum_ok;
    logic [FADE_W:0]    fade_dn_d;
    logic [FADE_W:0]    fade_up_d;

`ifdef IBNIZ_SEQ_PAUSE_EN
    assign ef = bus.end_frame & ~bus.pause;
`else
    assign ef = bus.end_frame;
`endif

    ibniz_next_scene u_auto_next (
        .cur_i  (scene_q),
        .mask_i (SCENE_MASK),
        .nxt_o  (auto_nxt)
    );

    // The tumbler scene is enabled exactly when it follows its predecessor.
    ibniz_next_scene u_tum_check (
        .cur_i  (bus.tumblers - SCENE_W'(1)),
        .mask_i (SCENE_MASK),
        .nxt_o  (tum_nxt)
    );

    assign tum_ok    = (tum_nxt == bus.tumblers);
    assign fade_dn_d = {1'b0, fade_q} - STEP9;
    assign fade_up_d = {1'b0, fade_q} + STEP9;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HOLD;
            hold_q   <= '0;
            scene_q  <= INIT_SCENE;
            target_q <= INIT_SCENE;
            t_q      <= '0;
            fade_q   <= '1;
            sw_q     <= 1'b0;
        end else begin
            sw_q <= 1'b0;
            if (ef) t_q <= t_q + T_W'(1);
            case (state_q)
                HOLD: begin
                    if (bus.auto_en) begin
                        if (bus.next_req || (ef && hold_q == HOLD_LAST)) begin
                            hold_q <= '0;
                            if (auto_nxt != scene_q) begin
                                target_q <= auto_nxt;
                                state_q  <= FADE_OUT;
                            end
                        end else if (ef) begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end else begin
                        hold_q <= '0;
                        if (bus.tumblers != scene_q && tum_ok) begin
                            target_q <= bus.tumblers;
                            state_q  <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (ef) begin
                        if (fade_dn_d[FADE_W] || fade_dn_d[FADE_W-1:0] == '0) begin
                            fade_q  <= '0;
                            state_q <= SWITCH;
                        end else begin
                            fade_q <= fade_dn_d[FADE_W-1:0];
                        end
                    end
                end
                SWITCH: begin
                    scene_q <= target_q;
                    sw_q    <= 1'b1;
                    state_q <= FADE_IN;
                end
                FADE_IN: begin
                    if (ef) begin
                        if (fade_up_d[FADE_W] || fade_up_d[FADE_W-1:0] == '1) begin
                            fade_q  <= '1;
                            state_q <= HOLD;
                        end else begin
                            fade_q <= fade_up_d[FADE_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.scene_sel    = scene_q;
    assign bus.t_frame      = t_q;
    assign bus.fade         = fade_q;
    assign bus.scene_switch = sw_q;

endmodule

// File: doc/ibniz_scene_sequencer.md
Name: ibniz_scene_sequencer

Overview:
Frame-synchronous controller that decides which Ibniz generator scene drives the video output, and when it switches.
- Keeps the 16-bit frame time counter that feeds the generators' T input.
- Selects the scene either from the tumblers (manual mode) or by auto-rotating through enabled scenes.
- Every scene change runs a brightness fade-out, switch, fade-in sequence.
- Sits between the frame-timing logic (end_frame) and the adapter's scene mux and YUV stage (scene_sel, fade).

Parameters:
HOLD_FRAMES, 600, frames a scene is shown in auto mode before the fade-out starts (≥1)
FADE_STEP, 8, fade decrement/increment applied per frame (1..255)
SCENE_MASK, 8'hFF, bit n=1 means scene n is compiled in and may be selected
INIT_SCENE, 7, scene selected after reset; its SCENE_MASK bit must be 1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
end_frame  in  1  one-cycle pulse at end of each frame
tumblers  in  3  manual scene request
auto_en  in  1  1 = auto-rotate, 0 = manual
next_req  in  1  pulse: skip to next enabled scene (auto mode only)
scene_sel  out  3  scene index for the generator mux
t_frame  out  16  frame counter, becomes T_in[31:16]
fade  out  8  brightness scale, 255 = full, 0 = black
scene_switch  out  1  one-cycle pulse when scene_sel changes

Behaviour:
Reset and timing
- Reset is synchronous, active-high. While rst=1, all outputs take these values:
  - scene_sel=INIT_SCENE, t_frame=0, fade=255, scene_switch=0
  - state=HOLD, hold_cnt=0, target=INIT_SCENE
- Reset mid-fade aborts the sequence immediately.
- All outputs are registered. Each output updates on the clk edge that samples end_frame=1, so latency is 1 cycle.
- t_frame increments by 1 on every end_frame in every state. It wraps 0xFFFF->0.

State HOLD (fade=255)
- auto_en=1:
  - hold_cnt increments on each end_frame.
  - When hold_cnt==HOLD_FRAMES-1 and end_frame=1, or when next_req=1 (any cycle): target=next_enabled(scene_sel), hold_cnt=0, go to FADE_OUT.
- auto_en=0: each cycle, if tumblers!=scene_sel and SCENE_MASK[tumblers]=1: target=tumblers, go to FADE_OUT.
  - Masked requests are ignored.
  - hold_cnt is held at 0.
- next_req is ignored in manual mode and in any state other than HOLD.
- next_enabled(s) is the first index after s, searching upward with wrap 7->0, whose mask bit is 1.
  - If only s itself is enabled, the result is s, no transition happens and hold_cnt just restarts.

State FADE_OUT
- On each end_frame: fade = max(fade-FADE_STEP, 0).
- On the end_frame where the new fade is 0, go to SWITCH.

State SWITCH (exactly 1 cycle, does not wait for end_frame)
- scene_sel=target, scene_switch=1 for this cycle, go to FADE_IN.

State FADE_IN
- On each end_frame: fade = min(fade+FADE_STEP, 255), saturating.
- On reaching 255, go to HOLD.

Target and mode changes during a sequence
- target is latched at FADE_OUT entry.
- Changes to tumblers or auto_en during FADE_OUT, SWITCH or FADE_IN are ignored. They are re-evaluated in HOLD.
- If auto_en toggles while in HOLD, hold_cnt is cleared.

Simultaneous events
- end_frame and next_req in the same HOLD cycle: next_req wins and the hold count is discarded.
- t_frame still increments in that cycle.

Optional Feature:
Macro IBNIZ_SEQ_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1:
  - t_frame, hold_cnt and fade are frozen (end_frame is ignored for them).
  - State transitions that depend on end_frame do not occur.
  - The HOLD manual/next_req transitions into FADE_OUT still happen, but the fade does not advance.
  - SWITCH still completes in 1 cycle.
- Not defined: no pause port; the behaviour is exactly as described above.

Decomposition:
- Package ibniz_pkg holds:
  - state enum (HOLD, FADE_OUT, SWITCH, FADE_IN), 2-bit
  - SCENE_W=3, T_W=16, FADE_W=8
  - the scene-number constants (0 munching++ … 7 test)
- One sub-module: ibniz_next_scene. Purely combinational, takes current scene and mask and returns the next enabled index. It is reused by the tumbler-decode logic.
- The FSM, counters and fade arithmetic live in the top module. Fade arithmetic is done at 9 bits to detect saturation.

Test Plan:
1. Reset: rst=1 for 2 clocks -> scene_sel=7, t_frame=0, fade=255, scene_switch=0. Then 5 end_frame pulses -> t_frame=5.
2. Auto rotate:
   - Setup: HOLD_FRAMES=4, FADE_STEP=128, SCENE_MASK=8'hFF, auto_en=1.
   - After 4 end_frames -> FADE_OUT.
   - Fade sequence 255->127->0.
   - Then one scene_switch pulse, with scene_sel 7->0 (wrap).
   - Then fade 128->255 and back to HOLD.
3. Masked skip: SCENE_MASK=8'b1000_0101, scene 0, next_req pulse -> target=2. Next next_req from 2 -> 7. From 7 -> 0.
4. Manual mode:
   - auto_en=0, tumblers=3 -> fade-out/switch/fade-in, ending with scene_sel=3.
   - tumblers changed to 5 mid-fade is ignored until HOLD, then a second sequence runs to 5.
   - tumblers=1 with mask bit 1=0 -> no change.
5. Boundary cases:
   - t_frame preset near 0xFFFF wraps to 0 on the next end_frame.
   - end_frame and next_req in the same cycle -> FADE_OUT entered, t_frame still increments.
   - rst asserted during FADE_IN -> fade=255, scene_sel=INIT_SCENE next cycle.
6. With IBNIZ_SEQ_PAUSE_EN defined:
   - pause=1 during FADE_OUT with fade=127 -> 10 end_frames leave fade=127 and t_frame unchanged.
   - Releasing pause resumes the fade sequence.
